// File: rtl/if_redirect_ctrl_pkg.sv
// Shared definitions for the fetch next-PC sequencer: branch kinds, FSM states, reset defaults.
package if_redirect_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEF     = 32'hbfc0_0000;
    localparam logic [31:0] BUNDLE_BYTES_DEF = 32'd8;

    typedef enum logic [1:0] {
        BR_B    = 2'd0,
        BR_J    = 2'd1,
        BR_JR   = 2'd2,
        BR_RSVD = 2'd3
    } br_kind_e;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DSLOT  = 2'd1,
        S_JRWAIT = 2'd2
    } fsm_state_e;

    function automatic logic [31:0] sext_imm16_x4(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/if_target_calc.sv
// Combinational branch target: PC-relative B, region-absolute J, register JR.
module if_target_calc
    import if_redirect_ctrl_pkg::*;
(
    input  logic [1:0]  br_kind,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_inst,
    input  logic [31:0] jr_op,
    output logic [31:0] target
);

    logic [31:0] seq_pc_s;

    assign seq_pc_s = br_pc + 32'd4;

    // Select the target form by branch kind; reserved kinds are never accepted upstream.
    always_comb begin
        target = seq_pc_s;
        case (br_kind_e'(br_kind))
            BR_B:    target = seq_pc_s + sext_imm16_x4(br_inst[15:0]);
            BR_J:    target = {seq_pc_s[31:28], br_inst[25:0], 2'b00};
            BR_JR:   target = jr_op;
            default: target = seq_pc_s;
        endcase
    end

endmodule

// File: rtl/if_redirect_ctrl.sv
// Fetch PC owner: merges interrupt, stalls and slot-1/slot-2 B/J/JR redirects into one registered PC.
module if_redirect_ctrl
    import if_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
    parameter logic [31:0] BUNDLE_BYTES = BUNDLE_BYTES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_req,
    input  logic [31:0] exc_pc,
    input  logic        stall_hard,
    input  logic        stall_soft,
    input  logic        br_valid,
    input  logic        br_slot,
    input  logic [1:0]  br_kind,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_inst,
    input  logic [31:0] jr_data,
    input  logic        jr_data_ok,
    output logic [31:0] pc,
    output logic        flush_id,
    output logic        kill_slot2,
    output logic        busy,
    output logic        br_drop
);

    fsm_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] jr_q, jr_d;
    logic        flush_q, flush_d;
    logic        kill2_q, kill2_d;

    br_kind_e    kind_s;
    logic [31:0] jr_op_s;
    logic [31:0] target_s;
    logic [31:0] pc_seq_s;
    logic        br_ok_s;
    logic        tgt_ready_s;

    assign kind_s      = br_kind_e'(br_kind);
    assign jr_op_s     = jr_data_ok ? jr_data : jr_q;
    assign pc_seq_s    = pc_q + BUNDLE_BYTES;
    assign br_ok_s     = br_valid && (kind_s != BR_RSVD) && (state_q == S_RUN);
    assign tgt_ready_s = (kind_s != BR_JR) || jr_data_ok;

    if_target_calc u_target_calc (
        .br_kind (br_kind),
        .br_pc   (br_pc),
        .br_inst (br_inst),
        .jr_op   (jr_op_s),
        .target  (target_s)
    );

    // State register: pc, FSM, target and JR latches, registered flush/kill.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            state_q <= S_RUN;
            tgt_q   <= 32'd0;
            jr_q    <= 32'd0;
            flush_q <= 1'b0;
            kill2_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            tgt_q   <= tgt_d;
            jr_q    <= jr_d;
            flush_q <= flush_d;
            kill2_q <= kill2_d;
        end
    end

    // Next state: JR data is captured every cycle, even under a hard stall.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        jr_d    = jr_data_ok ? jr_data : jr_q;
        if (int_req) begin
            pc_d    = exc_pc;
            state_d = S_RUN;
        end else if (stall_hard) begin
            state_d = state_q;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (br_ok_s) begin
                        tgt_d = target_s;
                        if (!br_slot && tgt_ready_s) begin
                            pc_d = target_s;
                        end else if (!br_slot) begin
                            state_d = S_JRWAIT;
                        end else begin
                            // Delay slot lives in the next bundle: fetch it before redirecting.
                            pc_d    = pc_seq_s;
                            state_d = tgt_ready_s ? S_DSLOT : S_JRWAIT;
                        end
                    end else if (stall_soft) begin
                        pc_d = pc_q;
                    end else begin
                        pc_d = pc_seq_s;
                    end
                end
                S_DSLOT: begin
                    pc_d    = tgt_q;
                    state_d = S_RUN;
                end
                S_JRWAIT: begin
                    if (jr_data_ok) begin
                        pc_d    = jr_data;
                        state_d = S_RUN;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                default: begin
                    pc_d    = pc_q;
                    state_d = S_RUN;
                end
            endcase
        end
    end

    // Outputs: next flush/kill values and the combinational protocol-error pulse.
    always_comb begin
        flush_d = 1'b0;
        kill2_d = 1'b0;
        br_drop = br_valid && !int_req && ((state_q != S_RUN) || (kind_s == BR_RSVD));
        if (int_req) begin
            flush_d = 1'b1;
        end else if (stall_hard) begin
            flush_d = 1'b0;
        end else if (state_q == S_DSLOT) begin
            kill2_d = 1'b1;
        end else if (state_d == S_JRWAIT) begin
            flush_d = 1'b1;
        end else if ((state_q == S_RUN) && !br_ok_s && stall_soft) begin
            flush_d = 1'b1;
        end else begin
            flush_d = 1'b0;
        end
    end

    assign pc         = pc_q;
    assign flush_id   = flush_q;
    assign kill_slot2 = kill2_q;
    assign busy       = (state_q != S_RUN);

endmodule

// File: tb/tb_if_redirect_ctrl.sv
// Self-checking bench for if_redirect_ctrl: directed scenarios plus randomized traffic vs. a reference model.
module tb_if_redirect_ctrl;

    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        int_req = 1'b0;
    logic [31:0] exc_pc = 32'd0;
    logic        stall_hard = 1'b0;
    logic        stall_soft = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_slot = 1'b0;
    logic [1:0]  br_kind = 2'd0;
    logic [31:0] br_pc = 32'd0;
    logic [31:0] br_inst = 32'd0;
    logic [31:0] jr_data = 32'd0;
    logic        jr_data_ok = 1'b0;
    logic [31:0] pc;
    logic        flush_id, kill_slot2, busy, br_drop;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: expected outputs plus pending-redirect bookkeeping.
    logic [31:0] m_pc, m_jr, m_dtgt;
    logic        m_flush, m_kill2, m_dslot, m_jrwait;

    if_redirect_ctrl dut (
        .clk(clk), .reset(reset), .int_req(int_req), .exc_pc(exc_pc),
        .stall_hard(stall_hard), .stall_soft(stall_soft), .br_valid(br_valid),
        .br_slot(br_slot), .br_kind(br_kind), .br_pc(br_pc), .br_inst(br_inst),
        .jr_data(jr_data), .jr_data_ok(jr_data_ok), .pc(pc), .flush_id(flush_id),
        .kill_slot2(kill_slot2), .busy(busy), .br_drop(br_drop)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_target(input logic [1:0] k, input logic [31:0] bpc,
                                               input logic [31:0] binst, input logic [31:0] jop);
        logic [31:0] off;
        off = {{16{binst[15]}}, binst[15:0]} * 32'd4;
        case (k)
            2'd0:    return bpc + 32'd4 + off;
            2'd1:    return ((bpc + 32'd4) & 32'hf000_0000) | ({6'd0, binst[25:0]} * 32'd4);
            default: return jop;
        endcase
    endfunction

    function automatic logic exp_drop();
        return br_valid && !int_req && (m_dslot || m_jrwait || br_kind == 2'd3);
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_jr = 32'd0; m_dtgt = 32'd0;
        m_flush = 1'b0; m_kill2 = 1'b0; m_dslot = 1'b0; m_jrwait = 1'b0;
    endtask

    task automatic model_update();
        logic [31:0] jop, t;
        jop = jr_data_ok ? jr_data : m_jr;
        t = ref_target(br_kind, br_pc, br_inst, jop);
        m_kill2 = 1'b0;
        if (int_req) begin
            m_pc = exc_pc; m_dslot = 1'b0; m_jrwait = 1'b0; m_flush = 1'b1;
        end else if (stall_hard) begin
            m_flush = 1'b0;
        end else if (m_dslot) begin
            m_pc = m_dtgt; m_dslot = 1'b0; m_kill2 = 1'b1; m_flush = 1'b0;
        end else if (m_jrwait) begin
            if (jr_data_ok) begin
                m_pc = jr_data; m_jrwait = 1'b0; m_flush = 1'b0;
            end else begin
                m_flush = 1'b1;
            end
        end else if (br_valid && br_kind != 2'd3) begin
            if (br_slot) m_pc = m_pc + 32'd8;
            if (br_kind == 2'd2 && !jr_data_ok) begin
                m_jrwait = 1'b1; m_flush = 1'b1;
            end else if (br_slot) begin
                m_dslot = 1'b1; m_dtgt = t; m_flush = 1'b0;
            end else begin
                m_pc = t; m_flush = 1'b0;
            end
        end else if (stall_soft) begin
            m_flush = 1'b1;
        end else begin
            m_pc = m_pc + 32'd8; m_flush = 1'b0;
        end
        m_jr = jop;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        int_req = 1'b0; stall_hard = 1'b0; stall_soft = 1'b0; br_valid = 1'b0;
        br_slot = 1'b0; br_kind = 2'd0; jr_data_ok = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        idle_inputs();
        reset = 1'b0;
        #2;
        model_reset();
        reset = 1'b1;
    endtask

    task automatic drive_br(input logic slot, input logic [1:0] kind,
                            input logic [31:0] bpc, input logic [31:0] inst);
        br_valid = 1'b1; br_slot = slot; br_kind = kind; br_pc = bpc; br_inst = inst;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({pc, flush_id, kill_slot2, busy} !== {RST_PC, 3'b000})
            $display("FAIL reset_state got pc=%h f/k/b=%b%b%b exp pc=%h f/k/b=000",
                     pc, flush_id, kill_slot2, busy, RST_PC);
        else n_pass++;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        for (int i = 1; i <= 2; i++) begin
            tick();
            exp_pc = RST_PC + 32'(i * 8);
            n_checks++;
            if (pc !== exp_pc) $display("FAIL seq_pc%0d got %h exp %h", i, pc, exp_pc);
            else n_pass++;
        end
    endtask

    task automatic test_b_slot0();
        drive_br(1'b0, 2'd0, 32'hbfc0_0010, 32'h1000_0004);
        #1;
        n_checks++;
        if (br_drop !== 1'b0) $display("FAIL b_slot0_drop got %b exp 0", br_drop);
        else n_pass++;
        tick();
        idle_inputs();
        n_checks++;
        if (pc !== 32'hbfc0_0024 || busy !== 1'b0)
            $display("FAIL b_slot0_pc got pc=%h busy=%b exp pc=bfc00024 busy=0", pc, busy);
        else n_pass++;
    endtask

    task automatic test_j_slot1();
        int kills = 0;
        apply_reset();
        tick();
        tick();
        drive_br(1'b1, 2'd1, 32'hbfc0_0014, 32'h0800_0100);
        tick();
        idle_inputs();
        kills += int'(kill_slot2);
        n_checks++;
        if (pc !== 32'hbfc0_0018 || busy !== 1'b1)
            $display("FAIL j_slot1_dslot got pc=%h busy=%b exp pc=bfc00018 busy=1", pc, busy);
        else n_pass++;
        tick();
        kills += int'(kill_slot2);
        n_checks++;
        if (pc !== 32'hb000_0400 || busy !== 1'b0)
            $display("FAIL j_slot1_target got pc=%h busy=%b exp pc=b0000400 busy=0", pc, busy);
        else n_pass++;
        tick();
        kills += int'(kill_slot2);
        n_checks++;
        if (kills !== 1 || pc !== 32'hb000_0408)
            $display("FAIL j_slot1_kill got kills=%0d pc=%h exp kills=1 pc=b0000408", kills, pc);
        else n_pass++;
    endtask

    task automatic test_jr_wait();
        logic [31:0] held_pc;
        held_pc = m_pc;
        drive_br(1'b0, 2'd2, held_pc + 32'd4, 32'h03e0_0008);
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_inputs();
            n_checks++;
            if (flush_id !== 1'b1 || busy !== 1'b1 || pc !== held_pc)
                $display("FAIL jr_wait%0d got f=%b busy=%b pc=%h exp f=1 busy=1 pc=%h",
                         i, flush_id, busy, pc, held_pc);
            else n_pass++;
        end
        jr_data = 32'h8000_1000;
        jr_data_ok = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (pc !== 32'h8000_1000 || busy !== 1'b0 || flush_id !== 1'b0)
            $display("FAIL jr_resolve got pc=%h busy=%b f=%b exp pc=80001000 busy=0 f=0",
                     pc, busy, flush_id);
        else n_pass++;
    endtask

    task automatic test_int_in_jrwait();
        drive_br(1'b1, 2'd2, m_pc + 32'd4, 32'h03e0_0008);
        tick();
        idle_inputs();
        tick();
        int_req = 1'b1; stall_hard = 1'b1; exc_pc = 32'hbfc0_0380;
        br_valid = 1'b1; br_kind = 2'd3;
        #1;
        n_checks++;
        if (br_drop !== 1'b0) $display("FAIL int_drop got %b exp 0", br_drop);
        else n_pass++;
        tick();
        idle_inputs();
        n_checks++;
        if (pc !== 32'hbfc0_0380 || busy !== 1'b0 || flush_id !== 1'b1)
            $display("FAIL int_redirect got pc=%h busy=%b f=%b exp pc=bfc00380 busy=0 f=1",
                     pc, busy, flush_id);
        else n_pass++;
    endtask

    task automatic test_drop();
        logic [31:0] tgt;
        tgt = 32'hbfc0_1000;
        drive_br(1'b1, 2'd0, tgt - 32'd4 - 32'h40, 32'h1000_0010);
        tick();
        drive_br(1'b0, 2'd1, 32'h0000_0100, 32'h0800_0abc);
        #1;
        n_checks++;
        if (br_drop !== 1'b1) $display("FAIL drop_dslot got %b exp 1", br_drop);
        else n_pass++;
        tick();
        idle_inputs();
        n_checks++;
        if (pc !== tgt || kill_slot2 !== 1'b1)
            $display("FAIL drop_dslot_pc got pc=%h k=%b exp pc=%h k=1", pc, kill_slot2, tgt);
        else n_pass++;
        drive_br(1'b0, 2'd3, pc, 32'h0800_0abc);
        #1;
        n_checks++;
        if (br_drop !== 1'b1) $display("FAIL drop_rsvd got %b exp 1", br_drop);
        else n_pass++;
        tick();
        idle_inputs();
        n_checks++;
        if (pc !== tgt + 32'd8 || busy !== 1'b0)
            $display("FAIL drop_rsvd_pc got pc=%h busy=%b exp pc=%h busy=0", pc, busy, tgt + 32'd8);
        else n_pass++;
    endtask

    task automatic test_random();
        logic exp_d;
        for (int i = 0; i < 2000; i++) begin
            int_req    = ($urandom_range(99) < 3);
            exc_pc     = $urandom & 32'hffff_fffc;
            stall_hard = ($urandom_range(99) < 8);
            stall_soft = ($urandom_range(99) < 10);
            br_valid   = ($urandom_range(99) < 25);
            br_slot    = 1'($urandom);
            br_kind    = 2'($urandom);
            br_pc      = $urandom & 32'hffff_fffc;
            br_inst    = $urandom;
            jr_data    = $urandom & 32'hffff_fffc;
            jr_data_ok = ($urandom_range(99) < 30);
            #1;
            exp_d = exp_drop();
            n_checks++;
            if (br_drop !== exp_d) $display("FAIL rnd_drop cyc=%0d got %b exp %b", i, br_drop, exp_d);
            else n_pass++;
            tick();
            n_checks++;
            if (pc !== m_pc || flush_id !== m_flush || kill_slot2 !== m_kill2 ||
                busy !== (m_dslot || m_jrwait))
                $display("FAIL rnd_out cyc=%0d got pc=%h f=%b k=%b b=%b exp pc=%h f=%b k=%b b=%b",
                         i, pc, flush_id, kill_slot2, busy, m_pc, m_flush, m_kill2,
                         m_dslot || m_jrwait);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        drive_br(1'b1, 2'd2, 32'h0000_2000, 32'h0);
        tick();
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({pc, flush_id, kill_slot2, busy} !== {RST_PC, 3'b000})
            $display("FAIL async_reset got pc=%h f/k/b=%b%b%b exp pc=%h f/k/b=000",
                     pc, flush_id, kill_slot2, busy, RST_PC);
        else n_pass++;
        model_reset();
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_b_slot0();
        test_j_slot1();
        test_jr_wait();
        test_int_in_jrwait();
        test_drop();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
